// File: rtl/ntt_bfly_sched.sv
// ---------------------------------------------------------------------------
// ntt_bfly_sched
//
// Address/twiddle scheduler for an in-place radix-2 NTT butterfly datapath.
// Walks one iterative Cooley-Tukey DIT transform (bit-reversed input,
// natural-order output). Each stage issues DEPTH/2 butterfly commands
// {addr_a, addr_b, twiddle exponent} over a valid/ready handshake, then
// waits PIPE cycles so the butterfly pipeline drains before the next stage
// reads its results. One scheduler serves both forward and inverse passes;
// the inverse flag is latched when a start is accepted.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      pulse: begin a transform (ignored while busy)
//   inverse    sampled with start; 1 selects inverse twiddles
//   bf_ready   datapath accepts the current command this cycle
//   bf_valid   command valid (only while issuing)
//   bf_addr_a  lower butterfly operand address
//   bf_addr_b  upper operand address (addr_a + 2^stage)
//   bf_tw_idx  twiddle exponent e (datapath uses w^e)
//   bf_stage   current stage index
//   bf_last    final butterfly of the final stage
//   busy       high from the first issue cycle through the done cycle
//   done       one-cycle pulse once the last stage has drained
// ---------------------------------------------------------------------------
module ntt_bfly_sched #(
    parameter int DEPTH = 256,
    parameter int LOGD  = $clog2(DEPTH),
    parameter int PIPE  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    inverse,
    input  logic                    bf_ready,
    output logic                    bf_valid,
    output logic [LOGD-1:0]         bf_addr_a,
    output logic [LOGD-1:0]         bf_addr_b,
    output logic [LOGD-1:0]         bf_tw_idx,
    output logic [$clog2(LOGD)-1:0] bf_stage,
    output logic                    bf_last,
    output logic                    busy,
    output logic                    done
);

    localparam int SW = $clog2(LOGD);
    localparam int JW = LOGD - 1;
    localparam int CW = (PIPE > 1) ? $clog2(PIPE) : 1;

    localparam logic [JW-1:0] J_LAST = JW'(DEPTH / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(LOGD - 1);
    localparam logic [CW-1:0] C_LAST = CW'((PIPE > 0) ? PIPE - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t        state_reg, state_next;
    logic [SW-1:0] stage_reg, stage_next;
    logic [JW-1:0] bfly_reg,  bfly_next;
    logic [CW-1:0] drain_reg, drain_next;
    logic          inv_reg,   inv_next;

    logic          accept;
    logic          valid_next, last_next, busy_next, done_next;
    logic [LOGD-1:0] addr_a_next, addr_b_next, tw_next;
    logic [SW-1:0] stage_out_next;

    // address-math temporaries
    logic [LOGD-1:0] jx, half, k, e;
    int              sh;

    // -----------------------------------------------------------------------
    // Next-state and next-output logic. Outputs are computed from the *next*
    // counters and registered, so bf_valid never depends combinationally on
    // bf_ready and a stalled command simply recomputes to the same value.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        stage_next = stage_reg;
        bfly_next  = bfly_reg;
        drain_next = drain_reg;
        inv_next   = inv_reg;
        accept     = bf_valid & bf_ready;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_ISSUE;
                    stage_next = '0;
                    bfly_next  = '0;
                    drain_next = '0;
                    inv_next   = inverse;
                end
            end
            ST_ISSUE: begin
                if (accept) begin
                    if (bfly_reg == J_LAST) begin
                        bfly_next = '0;
                        if (PIPE > 0) begin
                            state_next = ST_DRAIN;
                            drain_next = '0;
                        end else if (stage_reg == S_LAST) begin
                            state_next = ST_DONE;
                        end else begin
                            // no drain needed: next stage starts back-to-back
                            stage_next = stage_reg + 1'b1;
                        end
                    end else begin
                        bfly_next = bfly_reg + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // drain counts wall-clock cycles; bf_ready is irrelevant here
                if (drain_reg == C_LAST) begin
                    drain_next = '0;
                    if (stage_reg == S_LAST) begin
                        state_next = ST_DONE;
                    end else begin
                        stage_next = stage_reg + 1'b1;
                        state_next = ST_ISSUE;
                    end
                end else begin
                    drain_next = drain_reg + 1'b1;
                end
            end
            ST_DONE: begin
                // start here is deliberately ignored
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Butterfly j of stage s: k = j mod half; the pair sits in block
        // j/half of size 2*half; twiddle stride is DEPTH/(2*half).
        sh          = int'(stage_next);
        jx          = LOGD'(bfly_next);
        half        = LOGD'(1) << sh;
        k           = jx & (half - LOGD'(1));
        addr_a_next = ((jx >> sh) << (sh + 1)) | k;
        addr_b_next = addr_a_next | half;
        e           = k << (LOGD - 1 - sh);
        // inverse uses w^-e = w^(DEPTH-e); modular negate also maps 0 to 0
        tw_next     = inv_next ? (LOGD'(0) - e) : e;

        valid_next     = (state_next == ST_ISSUE);
        last_next      = valid_next && (stage_next == S_LAST) && (bfly_next == J_LAST);
        busy_next      = (state_next != ST_IDLE);
        done_next      = (state_next == ST_DONE);
        stage_out_next = valid_next ? stage_next : '0;
        if (!valid_next) begin
            addr_a_next = '0;
            addr_b_next = '0;
            tw_next     = '0;
        end
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            stage_reg <= '0;
            bfly_reg  <= '0;
            drain_reg <= '0;
            inv_reg   <= 1'b0;
            bf_valid  <= 1'b0;
            bf_addr_a <= '0;
            bf_addr_b <= '0;
            bf_tw_idx <= '0;
            bf_stage  <= '0;
            bf_last   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_reg <= state_next;
            stage_reg <= stage_next;
            bfly_reg  <= bfly_next;
            drain_reg <= drain_next;
            inv_reg   <= inv_next;
            bf_valid  <= valid_next;
            bf_addr_a <= addr_a_next;
            bf_addr_b <= addr_b_next;
            bf_tw_idx <= tw_next;
            bf_stage  <= stage_out_next;
            bf_last   <= last_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

endmodule
